ex_result_buffer: RTL and testbench

Two-entry result buffer directly downstream of `alu` in the execute stage. It captures each ALU result (`y`, `zero`) together with its destination register and write-enable, and presents results in order to the memory/writeback stage over a valid/ready handshake. It also gives decode a combinational bypass lookup, so a dependent instruction can take a buffered result before it reaches the register file.

---
 rtl/ex_result_buffer_pkg.sv | 16 +
 rtl/ex_result_buffer_rb_entry.sv | 65 ++++++
 rtl/ex_result_buffer.sv | 165 ++++++++++++++++
 tb/tb_ex_result_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_result_buffer_pkg.sv
// Shared constants and types for the execute-stage result buffer.
// Holds the register-index width default and the r0 index used by the capture rule.
package ex_result_buffer_pkg;

  localparam int RB_DW_DEF = 32;
  localparam int RB_RW_DEF = 5;
  localparam int RB_R0_IDX = 0;

  // Occupancy doubles as the control state of the buffer.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/ex_result_buffer_rb_entry.sv
// One buffered ALU result {y, zero, rd, wen} with synchronous load and clear.
// Clear has priority over load.
module rb_entry
  import ex_result_buffer_pkg::*;
#(
  parameter int DW = RB_DW_DEF,
  parameter int RW = RB_RW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [DW-1:0] y_i,
  input  logic          zero_i,
  input  logic [RW-1:0] rd_i,
  input  logic          wen_i,
  output logic [DW-1:0] y_o,
  output logic          zero_o,
  output logic [RW-1:0] rd_o,
  output logic          wen_o
);

  logic [DW-1:0] y_q,    y_d;
  logic          zero_q, zero_d;
  logic [RW-1:0] rd_q,   rd_d;
  logic          wen_q,  wen_d;

  always_comb begin
    y_d    = y_q;
    zero_d = zero_q;
    rd_d   = rd_q;
    wen_d  = wen_q;
    if (clr_i) begin
      y_d    = '0;
      zero_d = 1'b0;
      rd_d   = '0;
      wen_d  = 1'b0;
    end else if (load_i) begin
      y_d    = y_i;
      zero_d = zero_i;
      rd_d   = rd_i;
      wen_d  = wen_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '0;
      zero_q <= 1'b0;
      rd_q   <= '0;
      wen_q  <= 1'b0;
    end else begin
      y_q    <= y_d;
      zero_q <= zero_d;
      rd_q   <= rd_d;
      wen_q  <= wen_d;
    end
  end

  assign y_o    = y_q;
  assign zero_o = zero_q;
  assign rd_o   = rd_q;
  assign wen_o  = wen_q;

endmodule

// File: rtl/ex_result_buffer.sv
// Two-entry in-order result buffer between the ALU and memory/writeback,
// with a combinational bypass lookup for decode.
//   state     | meaning
//   OCC_EMPTY | no entries, H and T stale
//   OCC_ONE   | H valid
//   OCC_FULL  | H oldest, T youngest; in_ready low
module ex_result_buffer
  import ex_result_buffer_pkg::*;
#(
  parameter int DW = RB_DW_DEF,
  parameter int RW = RB_RW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_y,
  input  logic          in_zero,
  input  logic [RW-1:0] in_rd,
  input  logic          in_wen,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_y,
  output logic          out_zero,
  output logic [RW-1:0] out_rd,
  output logic          out_wen,
  input  logic          flush,
  input  logic [RW-1:0] fwd_rs,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data,
  output logic [1:0]    count
);

  localparam logic [RW-1:0] R0 = RW'(RB_R0_IDX);

  occ_e count_q, count_d;

  logic push, pop;
  logic h_load, t_load, h_from_t;
  logic cap_wen;

  logic [DW-1:0] h_y_in;
  logic          h_zero_in;
  logic [RW-1:0] h_rd_in;
  logic          h_wen_in;

  logic [DW-1:0] h_y, t_y;
  logic          h_zero, t_zero;
  logic [RW-1:0] h_rd, t_rd;
  logic          h_wen, t_wen;

  logic h_valid, t_valid, h_match, t_match;

  // Handshake decodes only from registered occupancy; out_ready never reaches in_ready.
  assign in_ready  = (count_q != OCC_FULL);
  assign out_valid = (count_q != OCC_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign cap_wen   = in_wen && (in_rd != R0);

  always_comb begin
    count_d  = count_q;
    h_load   = 1'b0;
    t_load   = 1'b0;
    h_from_t = 1'b0;
    if (flush) begin
      count_d = OCC_EMPTY;
    end else begin
      case (count_q)
        OCC_EMPTY: begin
          if (push) begin
            h_load  = 1'b1;
            count_d = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            h_load = 1'b1;
          end else if (push) begin
            t_load  = 1'b1;
            count_d = OCC_FULL;
          end else if (pop) begin
            count_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            h_load   = 1'b1;
            h_from_t = 1'b1;
            count_d  = OCC_ONE;
          end
        end
        default: count_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= OCC_EMPTY;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    h_y_in    = in_y;
    h_zero_in = in_zero;
    h_rd_in   = in_rd;
    h_wen_in  = cap_wen;
    if (h_from_t) begin
      h_y_in    = t_y;
      h_zero_in = t_zero;
      h_rd_in   = t_rd;
      h_wen_in  = t_wen;
    end
  end

  rb_entry #(.DW(DW), .RW(RW)) u_head (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (flush),
    .load_i (h_load),
    .y_i    (h_y_in),
    .zero_i (h_zero_in),
    .rd_i   (h_rd_in),
    .wen_i  (h_wen_in),
    .y_o    (h_y),
    .zero_o (h_zero),
    .rd_o   (h_rd),
    .wen_o  (h_wen)
  );

  rb_entry #(.DW(DW), .RW(RW)) u_tail (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (flush),
    .load_i (t_load),
    .y_i    (in_y),
    .zero_i (in_zero),
    .rd_i   (in_rd),
    .wen_i  (cap_wen),
    .y_o    (t_y),
    .zero_o (t_zero),
    .rd_o   (t_rd),
    .wen_o  (t_wen)
  );

  assign out_y    = out_valid ? h_y    : '0;
  assign out_zero = out_valid ? h_zero : 1'b0;
  assign out_rd   = out_valid ? h_rd   : '0;
  assign out_wen  = out_valid ? h_wen  : 1'b0;

  // Only registered entries are visible; the youngest match wins.
  assign h_valid = (count_q != OCC_EMPTY);
  assign t_valid = (count_q == OCC_FULL);
  assign h_match = h_valid && h_wen && (h_rd == fwd_rs) && (fwd_rs != R0);
  assign t_match = t_valid && t_wen && (t_rd == fwd_rs) && (fwd_rs != R0);

  assign fwd_hit  = h_match || t_match;
  assign fwd_data = t_match ? t_y : (h_match ? h_y : '0);

  assign count = count_q;

endmodule

// File: tb/tb_ex_result_buffer.sv
// Directed bench for ex_result_buffer with a queue scoreboard of expected results.
module tb_ex_result_buffer;

  typedef struct packed {
    logic [31:0] y;
    logic        zero;
    logic [4:0]  rd;
    logic        wen;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_y;
  logic        in_zero;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        out_valid, out_ready;
  logic [31:0] out_y;
  logic        out_zero;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        flush;
  logic [4:0]  fwd_rs;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [1:0]  count;

  int   checks = 0;
  int   failures = 0;
  int   pops = 0;
  ent_t sb[$];

  always #5 clk = ~clk;

  ex_result_buffer #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_zero(in_zero),
    .in_rd(in_rd), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero),
    .out_rd(out_rd), .out_wen(out_wen),
    .flush(flush), .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] y, input logic z,
                       input logic [4:0] rd, input logic wen);
    in_valid = v; in_y = y; in_zero = z; in_rd = rd; in_wen = wen;
  endtask

  // Check all outputs against the scoreboard at the negedge, then model the edge.
  task automatic step();
    logic        eh;
    logic [31:0] ed;
    logic        do_push;
    ent_t        e;
    eh = 1'b0;
    ed = '0;
    @(negedge clk);
    chk("count", 64'(count), 64'(sb.size()));
    chk("in_ready", 64'(in_ready), 64'(sb.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (!eh && sb[i].wen && sb[i].rd == fwd_rs && fwd_rs != 5'd0) begin
        eh = 1'b1;
        ed = sb[i].y;
      end
    end
    chk("fwd_hit", 64'(fwd_hit), 64'(eh));
    chk("fwd_data", 64'(fwd_data), 64'(ed));
    if (sb.size() == 0) begin
      chk("out_y_empty", 64'(out_y), 64'd0);
      chk("out_rd_empty", 64'(out_rd), 64'd0);
      chk("out_wen_empty", 64'(out_wen), 64'd0);
      chk("out_zero_empty", 64'(out_zero), 64'd0);
    end else begin
      chk("out_y", 64'(out_y), 64'(sb[0].y));
      chk("out_rd", 64'(out_rd), 64'(sb[0].rd));
      chk("out_wen", 64'(out_wen), 64'(sb[0].wen));
      chk("out_zero", 64'(out_zero), 64'(sb[0].zero));
    end
    do_push = in_valid && (sb.size() < 2);
    if (flush) begin
      sb.delete();
    end else begin
      if (sb.size() != 0 && out_ready) begin
        void'(sb.pop_front());
        pops++;
      end
      if (do_push) begin
        e.y = in_y; e.zero = in_zero; e.rd = in_rd;
        e.wen = in_wen && (in_rd != 5'd0);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 8 && sb.size() != 0; i++) step();
    chk("drain_done", 64'(sb.size()), 64'd0);
    step();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; fwd_rs = '0;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    fwd_rs = 5'd5;
    step();

    // Single result with zero-wait downstream
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_00FF, 1'b0, 5'd5, 1'b1);
    step();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    step();
    chk("single_pop", 64'(pops), 64'd1);
    step();
    chk("count_after_single", 64'(count), 64'd0);

    // Backpressure: A, B accepted, C held until space
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 1'b1, 5'd1, 1'b1); step();
    drive(1'b1, 32'hBBBB_0002, 1'b0, 5'd2, 1'b1); step();
    drive(1'b1, 32'hCCCC_0003, 1'b0, 5'd3, 1'b0); step();
    step();
    chk("full_count", 64'(count), 64'd2);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    step();
    step();
    drain();
    chk("abc_pops", 64'(pops), 64'd4);

    // Forwarding: youngest of two matches wins
    out_ready = 1'b0; fwd_rs = 5'd7;
    drive(1'b1, 32'd1, 1'b0, 5'd7, 1'b1); step();
    drive(1'b1, 32'd2, 1'b0, 5'd7, 1'b1); step();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    step();
    chk("fwd_two_hit", 64'(fwd_hit), 64'd1);
    chk("fwd_two_data", 64'(fwd_data), 64'd2);
    fwd_rs = 5'd9; step();
    fwd_rs = 5'd7; out_ready = 1'b1; step();
    chk("fwd_one_data", 64'(fwd_data), 64'd2);
    drain();

    // r0 is never forwarded and never written
    out_ready = 1'b0; fwd_rs = 5'd0;
    drive(1'b1, 32'h1234_5678, 1'b1, 5'd0, 1'b1); step();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    step();
    chk("r0_fwd_hit", 64'(fwd_hit), 64'd0);
    chk("r0_out_wen", 64'(out_wen), 64'd0);
    drain();

    // Flush at full with simultaneous push and pop
    out_ready = 1'b0; fwd_rs = 5'd4;
    drive(1'b1, 32'h0000_0011, 1'b0, 5'd4, 1'b1); step();
    drive(1'b1, 32'h0000_0022, 1'b0, 5'd6, 1'b1); step();
    chk("pre_flush_count", 64'(count), 64'd2);
    pops = 0;
    out_ready = 1'b1; flush = 1'b1;
    drive(1'b1, 32'h0000_0033, 1'b0, 5'd4, 1'b1);
    step();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_no_pop", 64'(pops), 64'd0);
    step();
    flush = 1'b0;
    step();
    chk("post_flush_count", 64'(count), 64'd1);
    drain();

    // Async reset between edges with one entry held
    out_ready = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 5'd8, 1'b1); step();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    fwd_rs = 5'd8;
    chk("pre_rst_count", 64'(count), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_y", 64'(out_y), 64'd0);
    chk("rst_out_rd", 64'(out_rd), 64'd0);
    chk("rst_out_wen", 64'(out_wen), 64'd0);
    chk("rst_out_zero", 64'(out_zero), 64'd0);
    chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
